// File: rtl/irq_sequencer_pkg.sv
// Shared types and helpers for the interrupt sequencer: FSM state encoding,
// the NPC select code for a return-from-interrupt, and RETI decode.
package irq_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SAFE = 2'd1,
    INJECT    = 2'd2
  } seqState_t;

  localparam logic [1:0] NPC_RETI = 2'b10;

  function automatic logic isReti(input logic branchInstr, input logic jumpInstr);
    return branchInstr & jumpInstr;
  endfunction

endpackage

// File: rtl/irq_sequencer_ret_stack.sv
// Return-PC LIFO: DEPTH x AW entries, push/pop with full/empty/top and an
// occupancy count; async active-low reset clears pointer and contents.
module ret_stack #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              pushData,
  output logic [AW-1:0]              top,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW:0]   cnt;
  logic [PW-1:0] topIdx;

  assign topIdx = PW'(cnt - 1'b1);
  assign empty  = (cnt == '0);
  assign full   = (cnt == (PW+1)'(DEPTH));
  assign top    = empty ? '0 : mem[topIdx];
  assign count  = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !full) begin
      mem[cnt[PW-1:0]] <= pushData;
      cnt              <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer around the branch unit, with a return-PC stack.
// Define IRQ_NEST_EN to allow nested entry up to DEPTH levels (default: single level).
module irq_sequencer
  import irq_seq_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   IrqReq,
  input  logic [AW-1:0]          IrqVector,
  output logic                   IrqAck,
  input  logic                   StallPipe,
  input  logic                   BranchInstr,
  input  logic                   JumpInstr,
  input  logic [AW-1:0]          ResumePc,
  output logic                   IRQ,
  output logic [AW-1:0]          IsrAddr,
  output logic [AW-1:0]          RetPc,
  output logic                   RetValid,
  output logic                   InIsr,
  output logic [$clog2(DEPTH):0] NestLvl,
  output logic                   ErrUnder
);

  seqState_t     state, stateNext;
  logic          reti, ctrl, accept;
  logic          doInject, doPop, doErr;
  logic          stkFull, stkEmpty;
  logic [AW-1:0] stkTop;

  ret_stack #(.AW(AW), .DEPTH(DEPTH)) uStack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (doInject),
    .pop      (doPop),
    .pushData (ResumePc),
    .top      (stkTop),
    .full     (stkFull),
    .empty    (stkEmpty),
    .count    (NestLvl)
  );

  assign InIsr = !stkEmpty;
  assign reti  = isReti(BranchInstr, JumpInstr);
  assign ctrl  = BranchInstr ^ JumpInstr;

`ifdef IRQ_NEST_EN
  assign accept = IrqReq && !stkFull;
`else
  assign accept = IrqReq && !stkFull && stkEmpty;
`endif

  // A RETI is honoured in every state so a return is never lost; it always
  // blocks injection in the same cycle, which yields the tail-chain ordering.
  always_comb begin
    stateNext = state;
    doInject  = 1'b0;
    doPop     = 1'b0;
    doErr     = 1'b0;
    if (!StallPipe) begin
      if (reti) begin
        doPop = !stkEmpty;
        doErr = stkEmpty;
      end
      unique case (state)
        IDLE: begin
          if (!reti && accept) begin
            if (ctrl) begin
              stateNext = WAIT_SAFE;
            end else begin
              doInject  = 1'b1;
              stateNext = INJECT;
            end
          end
        end
        WAIT_SAFE: begin
          if (!IrqReq) begin
            stateNext = IDLE;
          end else if (!reti && !ctrl) begin
            doInject  = 1'b1;
            stateNext = INJECT;
          end
        end
        INJECT:  stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      IRQ      <= 1'b0;
      IrqAck   <= 1'b0;
      IsrAddr  <= '0;
      RetValid <= 1'b0;
      RetPc    <= '0;
      ErrUnder <= 1'b0;
    end else begin
      state    <= stateNext;
      IRQ      <= doInject;
      IrqAck   <= doInject;
      IsrAddr  <= doInject ? IrqVector : '0;
      RetValid <= doPop;
      RetPc    <= doPop ? stkTop : '0;
      ErrUnder <= doErr;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: behavioural model (queue of return PCs)
// compared every cycle, plus directed literal checks. Honours IRQ_NEST_EN.
module tb_irq_sequencer;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          IrqReq = 1'b0;
  logic [AW-1:0] IrqVector = '0;
  logic          IrqAck;
  logic          StallPipe = 1'b0;
  logic          BranchInstr = 1'b0;
  logic          JumpInstr = 1'b0;
  logic [AW-1:0] ResumePc = '0;
  logic          IRQ;
  logic [AW-1:0] IsrAddr;
  logic [AW-1:0] RetPc;
  logic          RetValid;
  logic          InIsr;
  logic [2:0]    NestLvl;
  logic          ErrUnder;

  irq_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .IrqReq(IrqReq), .IrqVector(IrqVector), .IrqAck(IrqAck),
    .StallPipe(StallPipe), .BranchInstr(BranchInstr), .JumpInstr(JumpInstr),
    .ResumePc(ResumePc), .IRQ(IRQ), .IsrAddr(IsrAddr), .RetPc(RetPc),
    .RetValid(RetValid), .InIsr(InIsr), .NestLvl(NestLvl), .ErrUnder(ErrUnder)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  bit chkEn   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] retQ[$];
  bit          pending, injPhase;
  bit          mIrq, mAck, mRetValid, mErr;
  logic [31:0] mIsr, mRetPc;
`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retQ.delete();
      pending = 0; injPhase = 0;
      mIrq = 0; mAck = 0; mRetValid = 0; mErr = 0; mIsr = 0; mRetPc = 0;
    end else begin
      bit wasInj, isReti, doInj;
      mIrq = 0; mAck = 0; mRetValid = 0; mErr = 0; mIsr = 0; mRetPc = 0;
      if (!StallPipe) begin
        wasInj   = injPhase;
        injPhase = 0;
        isReti   = BranchInstr && JumpInstr;
        doInj    = 0;
        if (isReti) begin
          if (retQ.size() == 0) mErr = 1;
          else begin mRetPc = retQ.pop_back(); mRetValid = 1; end
        end
        if (wasInj) begin
        end else if (pending) begin
          if (!IrqReq) pending = 0;
          else if (!isReti && !(BranchInstr ^ JumpInstr)) doInj = 1;
        end else if (!isReti && IrqReq && retQ.size() < DEPTH && (NEST || retQ.size() == 0)) begin
          if (BranchInstr ^ JumpInstr) pending = 1;
          else doInj = 1;
        end
        if (doInj) begin
          retQ.push_back(ResumePc);
          mIrq = 1; mAck = 1; mIsr = IrqVector;
          pending = 0; injPhase = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("IRQ", 32'(IRQ), 32'(mIrq));
      chk("IrqAck", 32'(IrqAck), 32'(mAck));
      chk("IsrAddr", IsrAddr, mIsr);
      chk("RetValid", 32'(RetValid), 32'(mRetValid));
      chk("RetPc", RetPc, mRetPc);
      chk("ErrUnder", 32'(ErrUnder), 32'(mErr));
      chk("InIsr", 32'(InIsr), 32'(retQ.size() != 0));
      chk("NestLvl", 32'(NestLvl), 32'(retQ.size()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic doReti();
    BranchInstr = 1; JumpInstr = 1;
    tick();
    BranchInstr = 0; JumpInstr = 0;
  endtask

  int acks;

  initial begin
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    chkEn = 1;
    chk("rst_IRQ", 32'(IRQ), 32'd0);
    chk("rst_NestLvl", 32'(NestLvl), 32'd0);
    chk("rst_RetPc", RetPc, 32'd0);
    chk("rst_InIsr", 32'(InIsr), 32'd0);

    // basic entry, RETI, empty RETI
    IrqReq = 1; IrqVector = 32'h100; ResumePc = 32'h40;
    tick();
    chk("entry_IRQ", 32'(IRQ), 32'd1);
    chk("entry_Ack", 32'(IrqAck), 32'd1);
    chk("entry_IsrAddr", IsrAddr, 32'h100);
    chk("entry_NestLvl", 32'(NestLvl), 32'd1);
    IrqReq = 0;
    tick();
    chk("entry_pulse_end", 32'(IRQ), 32'd0);
    doReti();
    chk("reti_RetValid", 32'(RetValid), 32'd1);
    chk("reti_RetPc", RetPc, 32'h40);
    chk("reti_NestLvl", 32'(NestLvl), 32'd0);
    doReti();
    chk("under_Err", 32'(ErrUnder), 32'd1);
    chk("under_RetPc", RetPc, 32'd0);
    chk("under_NestLvl", 32'(NestLvl), 32'd0);

    // branch in EX delays entry until the slot is safe
    IrqReq = 1; IrqVector = 32'h180; ResumePc = 32'h60; BranchInstr = 1;
    tick();
    chk("wait1_IRQ", 32'(IRQ), 32'd0);
    tick();
    chk("wait2_IRQ", 32'(IRQ), 32'd0);
    BranchInstr = 0;
    tick();
    chk("wait_done_IRQ", 32'(IRQ), 32'd1);
    chk("wait_done_Isr", IsrAddr, 32'h180);
    IrqReq = 0;
    tick();
    doReti();
    chk("wait_RetPc", RetPc, 32'h60);

    // tail-chain: RETI and request in the same cycle
    IrqReq = 1; IrqVector = 32'h100; ResumePc = 32'h40;
    tick();
    IrqReq = 0;
    tick();
    IrqReq = 1; IrqVector = 32'h200; ResumePc = 32'h80;
    BranchInstr = 1; JumpInstr = 1;
    tick();
    BranchInstr = 0; JumpInstr = 0;
    chk("tail_RetValid", 32'(RetValid), 32'd1);
    chk("tail_noIRQ", 32'(IRQ), 32'd0);
    tick();
    chk("tail_IRQ", 32'(IRQ), 32'd1);
    chk("tail_Isr", IsrAddr, 32'h200);
    chk("tail_NestLvl", 32'(NestLvl), 32'd1);
    IrqReq = 0;
    tick();
    doReti();

    // held request against nesting limit
    IrqReq = 1; IrqVector = 32'h300; ResumePc = 32'h40; acks = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (IrqAck) begin acks++; ResumePc = ResumePc + 32'h4; end
    end
`ifdef IRQ_NEST_EN
    chk("nest_acks", 32'(acks), 32'd4);
    chk("nest_full", 32'(NestLvl), 32'd4);
    doReti();
    chk("nest_pop", RetPc, 32'h4C);
    chk("nest_lvl3", 32'(NestLvl), 32'd3);
    tick();
    chk("nest_fifth", 32'(IrqAck), 32'd1);
    chk("nest_lvl4", 32'(NestLvl), 32'd4);
    IrqReq = 0;
    tick();
    for (int i = 0; i < 4; i++) doReti();
`else
    chk("single_acks", 32'(acks), 32'd1);
    chk("single_lvl", 32'(NestLvl), 32'd1);
    doReti();
    chk("single_pop", RetPc, 32'h40);
    tick();
    chk("single_second", 32'(IrqAck), 32'd1);
    IrqReq = 0;
    tick();
    doReti();
`endif
    chk("unwind_lvl", 32'(NestLvl), 32'd0);

    // async reset while waiting for a safe slot, with stall toggling
    IrqReq = 1; IrqVector = 32'h400; ResumePc = 32'h90; BranchInstr = 1;
    tick();
    StallPipe = 1; tick();
    StallPipe = 0; tick();
    StallPipe = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_IRQ", 32'(IRQ), 32'd0);
    chk("arst_Ack", 32'(IrqAck), 32'd0);
    chk("arst_NestLvl", 32'(NestLvl), 32'd0);
    IrqReq = 0; BranchInstr = 0; StallPipe = 0;
    tick();
    rst_n = 1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (IrqAck) acks++;
    end
    chk("arst_noAck", 32'(acks), 32'd0);
    chk("arst_lvl", 32'(NestLvl), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int unsigned r;
      if (IrqAck) IrqReq = 0;
      else if (!IrqReq && $urandom_range(0, 3) == 0) begin
        IrqReq = 1; IrqVector = $urandom() & 32'hFFFF_FFFC;
      end
      ResumePc  = $urandom() & 32'hFFFF_FFFC;
      StallPipe = ($urandom_range(0, 6) == 0);
      r = $urandom_range(0, 9);
      BranchInstr = (r == 0) || (r == 2);
      JumpInstr   = (r == 1) || (r == 2);
      if ($urandom_range(0, 40) == 0) IrqReq = 0;
      tick();
    end
    BranchInstr = 0; JumpInstr = 0; IrqReq = 0; StallPipe = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
